// File: rtl/sched_pkg.sv
// Shared types, default constants and the set-bit search helper for task_scheduler.
package sched_pkg;

  localparam int unsigned SCHED_CLOCK_HZ       = 50_000_000;
  localparam int unsigned SCHED_TICK_DIV       = SCHED_CLOCK_HZ / 2;
  localparam int unsigned SCHED_TIMEOUT_CYCLES = 1024;
  localparam int unsigned SCHED_MAX_TASKS      = 8;

  typedef enum logic [1:0] {
    WAIT_TICK = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2,
    NEXT      = 2'd3
  } sched_state_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } bit_search_t;

  // Lowest set bit of mask at index >= from; found=0 when there is none.
  function automatic bit_search_t next_set_bit(input logic [SCHED_MAX_TASKS-1:0] mask,
                                               input logic [3:0] from);
    bit_search_t res;
    res = '0;
    for (int i = SCHED_MAX_TASKS - 1; i >= 0; i--) begin
      if (mask[i] && (4'(i) >= from)) begin
        res.found = 1'b1;
        res.idx   = 3'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/task_scheduler_tick.sv
// tick_prescaler: idle-interval counter; fires a one-cycle tick at DIV-1 while enabled.
module tick_prescaler
  import sched_pkg::*;
#(
  parameter int unsigned DIV = SCHED_TICK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             w_wrap;

  assign w_wrap = (r_cnt == CNT_W'(DIV - 1));
  assign o_tick = i_en && w_wrap;

  // Count while enabled, wrap on tick, restart when the round completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/task_scheduler.sv
// task_scheduler: periodic round sequencer over NUM_TASKS slots with heartbeat LED.
// Optional per-task watchdog enabled by defining SCHED_WATCHDOG_EN.
module task_scheduler
  import sched_pkg::*;
#(
  parameter  int unsigned CLOCK_HZ       = SCHED_CLOCK_HZ,
  parameter  int unsigned TICK_DIV       = CLOCK_HZ / 2,
  parameter  int unsigned NUM_TASKS      = 4,
  parameter  int unsigned TIMEOUT_CYCLES = SCHED_TIMEOUT_CYCLES,
  localparam int unsigned CUR_W          = (NUM_TASKS > 1) ? $clog2(NUM_TASKS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [NUM_TASKS-1:0] task_mask,
  input  logic [NUM_TASKS-1:0] task_done,
  output logic [NUM_TASKS-1:0] task_start,
  output logic [CUR_W-1:0]     cur_task,
  output logic                 busy,
  output logic                 led,
  output logic                 timeout_err
);

  // Reject unsupported configurations at elaboration.
  if ((TICK_DIV < 2) || (NUM_TASKS < 1) || (NUM_TASKS > SCHED_MAX_TASKS) ||
      (TIMEOUT_CYCLES < 2) || (CLOCK_HZ == 0)) begin : g_bad_params
    $error("task_scheduler: unsupported parameter combination");
  end

  sched_state_t         r_state, w_state_nxt;
  logic [NUM_TASKS-1:0] r_mask, w_mask_nxt;
  logic [CUR_W-1:0]     r_cur, w_cur_nxt;
  logic [NUM_TASKS-1:0] r_start, w_start_nxt;
  logic                 r_led, w_led_nxt;
  logic                 r_busy, w_busy_nxt;
  logic                 w_round_done;
  logic                 w_tick;
  logic                 w_done_sel;
  logic                 w_wd_timeout;
  bit_search_t          w_srch_tick, w_srch_next;

  assign w_done_sel  = task_done[r_cur];
  assign w_srch_tick = next_set_bit(SCHED_MAX_TASKS'(task_mask), 4'd0);
  assign w_srch_next = next_set_bit(SCHED_MAX_TASKS'(r_mask), 4'(r_cur) + 4'd1);

  tick_prescaler #(
    .DIV (TICK_DIV)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .i_en   (enable && (r_state == WAIT_TICK)),
    .i_clr  (w_round_done),
    .o_tick (w_tick)
  );

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_mask_nxt   = r_mask;
    w_cur_nxt    = r_cur;
    w_led_nxt    = r_led;
    w_round_done = 1'b0;
    case (r_state)
      WAIT_TICK: begin
        if (w_tick) begin
          w_mask_nxt = task_mask;
          if (w_srch_tick.found) begin
            w_cur_nxt   = CUR_W'(w_srch_tick.idx);
            w_state_nxt = START;
          end else begin
            w_state_nxt = NEXT;
          end
        end
      end
      START: w_state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        if (w_done_sel || w_wd_timeout) w_state_nxt = NEXT;
      end
      NEXT: begin
        if (w_srch_next.found) begin
          w_cur_nxt   = CUR_W'(w_srch_next.idx);
          w_state_nxt = START;
        end else begin
          w_led_nxt    = ~r_led;
          w_round_done = 1'b1;
          w_state_nxt  = WAIT_TICK;
        end
      end
      default: w_state_nxt = WAIT_TICK;
    endcase
    w_start_nxt = (w_state_nxt == START) ? (NUM_TASKS'(1) << w_cur_nxt) : '0;
    w_busy_nxt  = (w_state_nxt != WAIT_TICK);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= WAIT_TICK;
      r_mask  <= '0;
      r_cur   <= '0;
      r_start <= '0;
      r_led   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_mask  <= w_mask_nxt;
      r_cur   <= w_cur_nxt;
      r_start <= w_start_nxt;
      r_led   <= w_led_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

`ifdef SCHED_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES);

  logic [WD_W-1:0] r_wd_cnt;
  logic            r_timeout_err;

  assign w_wd_timeout = (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err  = r_timeout_err;

  // Cycles spent waiting on the current slot; cleared on its start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wd_cnt <= '0;
    end else if (r_state == START) begin
      r_wd_cnt <= '0;
    end else if (r_state == WAIT_DONE) begin
      r_wd_cnt <= r_wd_cnt + WD_W'(1);
    end
  end

  // Sticky error; a done arriving on the expiry cycle takes precedence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timeout_err <= 1'b0;
    end else if ((r_state == WAIT_DONE) && w_wd_timeout && !w_done_sel) begin
      r_timeout_err <= 1'b1;
    end
  end
`else
  assign w_wd_timeout = 1'b0;
  assign timeout_err  = 1'b0;
`endif

  assign task_start = r_start;
  assign cur_task   = r_cur;
  assign busy       = r_busy;
  assign led        = r_led;

endmodule

// File: tb/tb_task_scheduler.sv
// Directed bench for task_scheduler (TICK_DIV=8, NUM_TASKS=4, TIMEOUT_CYCLES=16).
// Watchdog scenario or no-watchdog scenario is chosen by SCHED_WATCHDOG_EN.
module tb_task_scheduler;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [3:0] task_mask;
  logic [3:0] task_done;
  logic [3:0] task_start;
  logic [1:0] cur_task;
  logic       busy;
  logic       led;
  logic       timeout_err;

  int n_cmp = 0;
  int n_err = 0;
  int n_starts = 0;

  // Task responder model: slot i raises done dly[i] cycles after its start (0 = never).
  int         dly [4];
  int         rem [4];
  bit         pend[4];
  logic [3:0] auto_done;
  logic [3:0] man_done;

  task_scheduler #(
    .TICK_DIV       (8),
    .NUM_TASKS      (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .task_mask   (task_mask),
    .task_done   (task_done),
    .task_start  (task_start),
    .cur_task    (cur_task),
    .busy        (busy),
    .led         (led),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge, update the responder and drive task_done.
  task automatic step();
    @(negedge clk);
    if (task_start != 4'b0000) n_starts++;
    auto_done = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (pend[i]) begin
        if (rem[i] <= 1) begin
          auto_done[i] = 1'b1;
          pend[i]      = 1'b0;
        end else begin
          rem[i]--;
        end
      end
      if (task_start[i] && (dly[i] > 0)) begin
        pend[i] = 1'b1;
        rem[i]  = dly[i];
      end
    end
    task_done = auto_done | man_done;
  endtask

  task automatic set_man(input logic [3:0] v);
    man_done  = v;
    task_done = auto_done | man_done;
  endtask

  task automatic set_dly(input int d0, input int d1, input int d2, input int d3);
    dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = d3;
  endtask

  task automatic assert_rst();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) pend[i] = 1'b0;
    auto_done = 4'b0000;
    set_man(4'b0000);
  endtask

  // Step until a start pulse appears or the bound runs out (slot=-1 then).
  task automatic wait_start(input int bound, output int slot, output int dt);
    slot = -1;
    dt   = 0;
    while ((dt < bound) && (slot < 0)) begin
      step();
      dt++;
      if (task_start != 4'b0000) begin
        for (int i = 0; i < 4; i++) if (task_start[i]) slot = i;
        chk("start_onehot", $countones(task_start), 1);
      end
    end
  endtask

  task automatic expect_start(input string tag, input int exp_slot, input int exp_dt);
    int slot, dt;
    wait_start(exp_dt + 4, slot, dt);
    chk({tag, "_slot"}, slot, exp_slot);
    chk({tag, "_dt"}, dt, exp_dt);
    chk({tag, "_cur"}, int'(cur_task), exp_slot);
    chk({tag, "_busy"}, int'(busy), 1);
  endtask

  initial begin
    int slot, dt, n0;
    enable    = 1'b0;
    task_mask = 4'b0000;
    task_done = 4'b0000;
    auto_done = 4'b0000;
    set_dly(3, 3, 3, 3);
    assert_rst();
    step();
    step();

    // Reset state
    chk("rst_start", int'(task_start), 0);
    chk("rst_cur", int'(cur_task), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_led", int'(led), 0);
    chk("rst_terr", int'(timeout_err), 0);

    // Mask 1011, done 3 cycles after each start: slots 0,1,3
    task_mask = 4'b1011;
    enable    = 1'b1;
    rst       = 1'b0;
    expect_start("t1_s0", 0, 8);
    expect_start("t1_s1", 1, 5);
    expect_start("t1_s3", 3, 5);
    repeat (4) step();
    chk("t1_next_busy", int'(busy), 1);
    chk("t1_next_led", int'(led), 0);
    step();
    chk("t1_end_busy", int'(busy), 0);
    chk("t1_end_led", int'(led), 1);
    expect_start("t1_r2_s0", 0, 8);
    // Mask change mid-round only takes effect at the next tick
    task_mask = 4'b0100;
    expect_start("t1_r2_s1", 1, 5);
    expect_start("t1_r2_s3", 3, 5);
    expect_start("t1_r3_s2", 2, 13);
    chk("t1_r3_led", int'(led), 0);
    // Enable low mid-round: round finishes, then the tick counter holds
    enable = 1'b0;
    wait_start(25, slot, dt);
    chk("t1_hold_nostart", slot, -1);
    chk("t1_hold_led", int'(led), 1);
    chk("t1_hold_busy", int'(busy), 0);
    enable = 1'b1;
    expect_start("t1_resume", 2, 8);

    // Foreign done and done coincident with start are ignored
    assert_rst();
    step();
    step();
    set_dly(0, 0, 0, 0);
    task_mask = 4'b0101;
    rst       = 1'b0;
    expect_start("t4_s0", 0, 8);
    n0 = n_starts;
    set_man(4'b0101);
    step();
    set_man(4'b0100);
    step();
    step();
    set_man(4'b0000);
    repeat (3) step();
    chk("t4_nostart", n_starts - n0, 0);
    chk("t4_busy", int'(busy), 1);
    chk("t4_cur", int'(cur_task), 0);
    set_man(4'b0001);
    step();
    set_man(4'b0000);
    expect_start("t4_s2", 2, 1);

    // Asynchronous reset in WAIT_DONE of slot 2
    step();
    step();
    chk("t5_pre_cur", int'(cur_task), 2);
    assert_rst();
    #1;
    chk("t5_async_busy", int'(busy), 0);
    chk("t5_async_cur", int'(cur_task), 0);
    chk("t5_async_start", int'(task_start), 0);
    chk("t5_async_led", int'(led), 0);
    step();
    step();
    set_dly(3, 3, 3, 3);
    rst = 1'b0;
    expect_start("t5_first", 0, 8);
    // Reset during the start cycle drops the pulse
    assert_rst();
    #1;
    chk("t5_drop_start", int'(task_start), 0);
    step();
    step();

    // Empty mask: led toggles every 9 cycles, busy only in the transition cycle
    task_mask = 4'b0000;
    n0        = n_starts;
    rst       = 1'b0;
    for (int i = 1; i <= 27; i++) begin
      step();
      chk($sformatf("t2_busy_c%0d", i), int'(busy), ((i % 9) == 8) ? 1 : 0);
      chk($sformatf("t2_led_c%0d", i), int'(led), (i / 9) % 2);
    end
    chk("t2_nostart", n_starts - n0, 0);
    assert_rst();
    #1;
    chk("t2_async_led", int'(led), 0);
    step();
    step();

`ifdef SCHED_WATCHDOG_EN
    // Slot 1 never answers: watchdog expires after 16 cycles in WAIT_DONE
    set_dly(2, 0, 0, 0);
    task_mask = 4'b0011;
    rst       = 1'b0;
    expect_start("t3_s0", 0, 8);
    expect_start("t3_s1", 1, 4);
    repeat (16) step();
    chk("t3_pre_terr", int'(timeout_err), 0);
    chk("t3_pre_cur", int'(cur_task), 1);
    step();
    chk("t3_terr", int'(timeout_err), 1);
    chk("t3_next_busy", int'(busy), 1);
    step();
    chk("t3_end_busy", int'(busy), 0);
    chk("t3_end_led", int'(led), 1);
    expect_start("t3_r2_s0", 0, 8);
    chk("t3_sticky", int'(timeout_err), 1);
    assert_rst();
    #1;
    chk("t3_rst_terr", int'(timeout_err), 0);
    step();
    rst = 1'b0;
`else
    // No watchdog: slot 0 never answers, scheduler waits indefinitely
    begin
      int terr_seen;
      set_dly(0, 0, 0, 0);
      task_mask = 4'b0001;
      rst       = 1'b0;
      expect_start("t6_s0", 0, 8);
      n0        = n_starts;
      terr_seen = 0;
      repeat (120) begin
        step();
        if (timeout_err) terr_seen = 1;
      end
      chk("t6_terr", terr_seen, 0);
      chk("t6_nostart", n_starts - n0, 0);
      chk("t6_busy", int'(busy), 1);
      chk("t6_cur", int'(cur_task), 0);
      set_man(4'b0001);
      step();
      set_man(4'b0000);
      chk("t6_next_busy", int'(busy), 1);
      step();
      chk("t6_end_busy", int'(busy), 0);
      chk("t6_end_led", int'(led), 1);
      expect_start("t6_r2_s0", 0, 8);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
